// File: rtl/drive_pkg.sv
// drive_pkg: types and helpers shared by the mode FSM and the motor drive.
//   drive_state_e : 4-bit drive code produced by the mode FSM.
//   chan_state_e  : per-channel ramp/reversal state.
//   chan_tgt_t    : requested (direction, duty) for one motor.
//   drive_tgt_t   : requested targets for both motors.
//   drive_targets : maps a drive code to the per-side targets.
package drive_pkg;

    typedef enum logic [3:0] {
        STOP     = 4'd0,
        LEFT     = 4'd1,
        RIGHT    = 4'd2,
        SLOW     = 4'd3,
        MEDIUM   = 4'd4,
        FAST     = 4'd5,
        REVERSE  = 4'd6,
        LREVERSE = 4'd7,
        RREVERSE = 4'd8
    } drive_state_e;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        RAMP_DOWN = 2'd1,
        DEAD      = 2'd2
    } chan_state_e;

    localparam logic DIR_FWD = 1'b1;
    localparam logic DIR_REV = 1'b0;

    typedef struct packed {
        logic       dir;
        logic [7:0] duty;
    } chan_tgt_t;

    typedef struct packed {
        chan_tgt_t left;
        chan_tgt_t right;
    } drive_tgt_t;

    // A zero-duty target carries no direction; the dir field is then a
    // don't-care and the channel keeps its present direction.
    function automatic drive_tgt_t drive_targets(input logic [3:0] code,
                                                 input logic [7:0] slow,
                                                 input logic [7:0] med,
                                                 input logic [7:0] fast,
                                                 input logic [7:0] turn);
        drive_tgt_t t;
        t.left  = '{dir: DIR_FWD, duty: 8'd0};
        t.right = '{dir: DIR_FWD, duty: 8'd0};
        case (code)
            LEFT:     t.right = '{dir: DIR_FWD, duty: turn};
            RIGHT:    t.left  = '{dir: DIR_FWD, duty: turn};
            SLOW: begin
                t.left  = '{dir: DIR_FWD, duty: slow};
                t.right = '{dir: DIR_FWD, duty: slow};
            end
            MEDIUM: begin
                t.left  = '{dir: DIR_FWD, duty: med};
                t.right = '{dir: DIR_FWD, duty: med};
            end
            FAST: begin
                t.left  = '{dir: DIR_FWD, duty: fast};
                t.right = '{dir: DIR_FWD, duty: fast};
            end
            REVERSE: begin
                t.left  = '{dir: DIR_REV, duty: slow};
                t.right = '{dir: DIR_REV, duty: slow};
            end
            LREVERSE: t.right = '{dir: DIR_REV, duty: turn};
            RREVERSE: t.left  = '{dir: DIR_REV, duty: turn};
            default:  ;  // STOP and unused codes 9..15
        endcase
        return t;
    endfunction

endpackage

// File: rtl/motor_drive_if.sv
// motor_drive_if: signal bundle between the mode FSM side and motor_drive.
//   drive_state, estop               : commands into the drive
//   pwm_l/r, dir_l/r, duty_l/r, busy : H-bridge controls and status out
// master = commanding side (FSM / bench), slave = motor_drive.
interface motor_drive_if;
    logic [3:0] drive_state;
    logic       estop;
    logic       pwm_l;
    logic       pwm_r;
    logic       dir_l;
    logic       dir_r;
    logic [7:0] duty_l;
    logic [7:0] duty_r;
    logic       busy;

    modport master (
        output drive_state, estop,
        input  pwm_l, pwm_r, dir_l, dir_r, duty_l, duty_r, busy
    );

    modport slave (
        input  drive_state, estop,
        output pwm_l, pwm_r, dir_l, dir_r, duty_l, duty_r, busy
    );
endinterface

// File: rtl/motor_channel.sv
// motor_channel: one motor output. Ramps the applied duty toward the target
// on ramp ticks, forces a ramp-down to zero plus a dead time before any
// direction reversal, and compares duty against the shared PWM counter.
// Ports:
//   clk_50, rst_n : clock, asynchronous active-low reset
//   tgt_i         : requested (direction, duty)
//   ramp_tick_i   : one-cycle ramp strobe
//   estop_i       : immediate stop, level
//   pwm_cnt_i     : shared 8-bit PWM counter
//   pwm_o, dir_o, duty_o : H-bridge enable, direction, applied duty
//   busy_o        : channel not in RUN or duty not yet at target
module motor_channel
    import drive_pkg::*;
#(
    parameter int  RAMP_STEP = 4,
    parameter int  DEADTIME  = 500000,
    localparam int DW        = $clog2(DEADTIME + 1)
) (
    input  logic       clk_50,
    input  logic       rst_n,
    input  chan_tgt_t  tgt_i,
    input  logic       ramp_tick_i,
    input  logic       estop_i,
    input  logic [7:0] pwm_cnt_i,
    output logic       pwm_o,
    output logic       dir_o,
    output logic [7:0] duty_o,
    output logic       busy_o
);

    localparam logic [7:0]    STEP      = 8'(RAMP_STEP);
    localparam logic [DW-1:0] DEAD_LOAD = DW'(DEADTIME);
    localparam logic [DW-1:0] DEAD_ONE  = DW'(1);

    chan_state_e   state_q, state_d;
    logic [7:0]    duty_q, duty_d;
    logic          dir_q, dir_d;
    logic [DW-1:0] dead_q, dead_d;
    logic          pwm_q, pwm_d;

    logic          rev_req;
    logic [7:0]    goal;
    logic [7:0]    ramped;
    logic [8:0]    up_sum;

    // A reversal is only requested by a non-zero target in the other direction.
    assign rev_req = (tgt_i.duty != 8'd0) && (tgt_i.dir != dir_q);
    // While a reversal is pending the ramp heads for zero instead of the target.
    assign goal    = rev_req ? 8'd0 : tgt_i.duty;
    assign up_sum  = {1'b0, duty_q} + {1'b0, STEP};

    // One ramp step toward goal, saturating exactly at goal.
    always_comb begin
        ramped = duty_q;
        if (duty_q < goal) begin
            ramped = (up_sum >= {1'b0, goal}) ? goal : up_sum[7:0];
        end else if (duty_q > goal) begin
            ramped = ((duty_q - goal) <= STEP) ? goal : (duty_q - STEP);
        end
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            duty_q  <= 8'd0;
            dir_q   <= DIR_FWD;
            dead_q  <= '0;
            pwm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            dir_q   <= dir_d;
            dead_q  <= dead_d;
            pwm_q   <= pwm_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (estop_i) begin
            state_d = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (rev_req) state_d = RAMP_DOWN;
                end
                RAMP_DOWN: begin
                    // Request swung back to the present direction: abort.
                    if (!rev_req && (tgt_i.duty != 8'd0)) state_d = RUN;
                    else if (duty_q == 8'd0)              state_d = DEAD;
                end
                DEAD: begin
                    if (dead_q <= DEAD_ONE) state_d = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        duty_d = duty_q;
        dir_d  = dir_q;
        dead_d = dead_q;
        pwm_d  = !estop_i && (pwm_cnt_i < duty_q);
        if (estop_i) begin
            duty_d = 8'd0;
            dead_d = '0;
        end else begin
            case (state_q)
                RUN, RAMP_DOWN: begin
                    if (ramp_tick_i) duty_d = ramped;
                    if ((state_q == RAMP_DOWN) && (state_d == DEAD)) dead_d = DEAD_LOAD;
                end
                DEAD: begin
                    duty_d = 8'd0;
                    dead_d = (dead_q == '0) ? '0 : (dead_q - DEAD_ONE);
                    // Flip on the cycle the counter expires, using the
                    // target registered that same cycle.
                    if ((dead_q <= DEAD_ONE) && (tgt_i.duty != 8'd0)) dir_d = tgt_i.dir;
                end
                default: ;
            endcase
        end
    end

    assign pwm_o  = pwm_q;
    assign dir_o  = dir_q;
    assign duty_o = duty_q;
    assign busy_o = (state_q != RUN) || (duty_q != tgt_i.duty);

endmodule

// File: rtl/motor_drive.sv
// motor_drive: converts the FSM drive code into two ramped PWM motor
// channels with safe direction reversal.
// Ports:
//   clk_50 : system clock
//   rst_n  : asynchronous active-low reset
//   bus    : motor_drive_if.slave (drive_state, estop in; pwm_l/r,
//            dir_l/r, duty_l/r, busy out)
// Holds the drive-code register, PWM prescaler/counter, free-running ramp
// tick generator and busy combine; the per-motor logic is motor_channel.
module motor_drive
    import drive_pkg::*;
#(
    parameter int PWM_PRESCALE = 98,
    parameter int RAMP_DIV     = 50000,
    parameter int RAMP_STEP    = 4,
    parameter int DEADTIME     = 500000,
    parameter int DUTY_SLOW    = 96,
    parameter int DUTY_MED     = 160,
    parameter int DUTY_FAST    = 240,
    parameter int DUTY_TURN    = 128
) (
    input  logic          clk_50,
    input  logic          rst_n,
    motor_drive_if.slave  bus
);

    localparam int PW = $clog2(PWM_PRESCALE + 1);
    localparam int RW = $clog2(RAMP_DIV + 1);

    logic [3:0]    code_q;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    pwm_cnt_q, pwm_cnt_d;
    logic [RW-1:0] ramp_q, ramp_d;
    logic          ramp_tick;

    drive_tgt_t    tgt;
    chan_tgt_t     tgt_ch  [2];
    logic          pwm_w   [2];
    logic          dir_w   [2];
    logic [7:0]    duty_w  [2];
    logic          busy_w  [2];

    // Ramp tick is free-running; drive code changes never re-phase it.
    assign ramp_tick = (ramp_q == RW'(RAMP_DIV - 1));

    always_comb begin
        presc_d   = presc_q + PW'(1);
        pwm_cnt_d = pwm_cnt_q;
        if (presc_q == PW'(PWM_PRESCALE - 1)) begin
            presc_d   = '0;
            pwm_cnt_d = pwm_cnt_q + 8'd1;  // wraps 255 -> 0
        end
        ramp_d = ramp_tick ? '0 : (ramp_q + RW'(1));
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            code_q    <= STOP;
            presc_q   <= '0;
            pwm_cnt_q <= 8'd0;
            ramp_q    <= '0;
        end else begin
            code_q    <= bus.drive_state;
            presc_q   <= presc_d;
            pwm_cnt_q <= pwm_cnt_d;
            ramp_q    <= ramp_d;
        end
    end

    assign tgt = drive_targets(code_q, 8'(DUTY_SLOW), 8'(DUTY_MED),
                               8'(DUTY_FAST), 8'(DUTY_TURN));
    assign tgt_ch[0] = tgt.left;
    assign tgt_ch[1] = tgt.right;

    // Channel 0 = left motor, channel 1 = right motor.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            motor_channel #(
                .RAMP_STEP (RAMP_STEP),
                .DEADTIME  (DEADTIME)
            ) u_chan (
                .clk_50      (clk_50),
                .rst_n       (rst_n),
                .tgt_i       (tgt_ch[gi]),
                .ramp_tick_i (ramp_tick),
                .estop_i     (bus.estop),
                .pwm_cnt_i   (pwm_cnt_q),
                .pwm_o       (pwm_w[gi]),
                .dir_o       (dir_w[gi]),
                .duty_o      (duty_w[gi]),
                .busy_o      (busy_w[gi])
            );
        end
    endgenerate

    assign bus.pwm_l  = pwm_w[0];
    assign bus.pwm_r  = pwm_w[1];
    assign bus.dir_l  = dir_w[0];
    assign bus.dir_r  = dir_w[1];
    assign bus.duty_l = duty_w[0];
    assign bus.duty_r = duty_w[1];
    assign bus.busy   = busy_w[0] | busy_w[1];

endmodule

// File: tb/tb_motor_drive.sv
// tb_motor_drive: scoreboard bench for motor_drive. The stimulus process
// advances a behavioural model one clock per step and queues the expected
// outputs; a monitor pops and compares one entry just after each edge.
module tb_motor_drive;
    import drive_pkg::*;

    localparam int PWM_PRESCALE = 1;
    localparam int RAMP_DIV     = 4;
    localparam int RAMP_STEP    = 4;
    localparam int DEADTIME     = 8;

    typedef struct packed {
        logic       pwm_l, pwm_r, dir_l, dir_r;
        logic [7:0] duty_l, duty_r;
        logic       busy;
    } obs_t;

    typedef struct {
        int duty;
        bit dir;
        bit winding;   // ramping down toward a reversal
        int dead_left; // dead-time cycles still to run
        bit pwm;
    } ch_model_t;

    logic clk_50 = 1'b0;
    logic rst_n  = 1'b0;
    motor_drive_if bus ();

    motor_drive #(
        .PWM_PRESCALE (PWM_PRESCALE),
        .RAMP_DIV     (RAMP_DIV),
        .RAMP_STEP    (RAMP_STEP),
        .DEADTIME     (DEADTIME)
    ) dut (
        .clk_50 (clk_50),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 clk_50 = ~clk_50;

    int        checks = 0;
    int        errors = 0;
    obs_t      exp_q [$];
    ch_model_t mch [2];
    int        m_code;
    int        m_n;

    // Spec table: target (duty, dir) for a drive code on side 0=left, 1=right.
    function automatic void target(input int code, input int side,
                                   output int duty, output bit dir);
        duty = 0;
        dir  = 1'b1;
        case (code)
            1: if (side == 1) duty = 128;
            2: if (side == 0) duty = 128;
            3: duty = 96;
            4: duty = 160;
            5: duty = 240;
            6: begin duty = 96; dir = 1'b0; end
            7: if (side == 1) begin duty = 128; dir = 1'b0; end
            8: if (side == 0) begin duty = 128; dir = 1'b0; end
            default: ;
        endcase
    endfunction

    task automatic model_reset();
        m_n    = 0;
        m_code = 0;
        for (int s = 0; s < 2; s++) begin
            mch[s].duty      = 0;
            mch[s].dir       = 1'b1;
            mch[s].winding   = 1'b0;
            mch[s].dead_left = 0;
            mch[s].pwm       = 1'b0;
        end
    endtask

    // Advance the model across one clock edge with the given inputs.
    task automatic model_step(input int ds, input bit es);
        bit   tick;
        int   cnt, td, goal;
        bit   tdir, want_rev;
        obs_t e;
        bit   bsy;
        tick = ((m_n % RAMP_DIV) == RAMP_DIV - 1);
        cnt  = (m_n / PWM_PRESCALE) % 256;
        for (int s = 0; s < 2; s++) begin
            target(m_code, s, td, tdir);
            mch[s].pwm = !es && (cnt < mch[s].duty);
            if (es) begin
                mch[s].duty      = 0;
                mch[s].winding   = 1'b0;
                mch[s].dead_left = 0;
            end else if (mch[s].dead_left > 0) begin
                mch[s].dead_left--;
                if (mch[s].dead_left == 0 && td > 0) mch[s].dir = tdir;
            end else begin
                want_rev = (td > 0) && (tdir != mch[s].dir);
                goal     = want_rev ? 0 : td;
                if (mch[s].winding && !want_rev && td > 0) begin
                    mch[s].winding = 1'b0;
                end else if (mch[s].winding && mch[s].duty == 0) begin
                    mch[s].winding   = 1'b0;
                    mch[s].dead_left = DEADTIME;
                end else if (want_rev) begin
                    mch[s].winding = 1'b1;
                end
                if (tick) begin
                    if (mch[s].duty < goal)
                        mch[s].duty = (mch[s].duty + RAMP_STEP > goal) ? goal : mch[s].duty + RAMP_STEP;
                    else if (mch[s].duty > goal)
                        mch[s].duty = (mch[s].duty - RAMP_STEP < goal) ? goal : mch[s].duty - RAMP_STEP;
                end
            end
        end
        m_code = ds;
        m_n++;
        bsy = 1'b0;
        for (int s = 0; s < 2; s++) begin
            target(m_code, s, td, tdir);
            if (mch[s].winding || mch[s].dead_left > 0 || mch[s].duty != td) bsy = 1'b1;
        end
        e.pwm_l  = mch[0].pwm;
        e.pwm_r  = mch[1].pwm;
        e.dir_l  = mch[0].dir;
        e.dir_r  = mch[1].dir;
        e.duty_l = 8'(mch[0].duty);
        e.duty_r = 8'(mch[1].duty);
        e.busy   = bsy;
        exp_q.push_back(e);
    endtask

    // Called at a negedge: apply inputs, queue expectation, wait one cycle.
    task automatic step(input int ds, input bit es);
        bus.drive_state = 4'(ds);
        bus.estop       = es;
        model_step(ds, es);
        @(negedge clk_50);
    endtask

    task automatic hold(input int ds, input int cycles);
        for (int i = 0; i < cycles; i++) step(ds, 1'b0);
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b, want %b", name, got, want);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_bit({tag, "_pwm_l"}, bus.pwm_l, 1'b0);
        check_bit({tag, "_pwm_r"}, bus.pwm_r, 1'b0);
        check_bit({tag, "_dir_l"}, bus.dir_l, 1'b1);
        check_bit({tag, "_dir_r"}, bus.dir_r, 1'b1);
        check_bit({tag, "_duty0"}, (bus.duty_l == 8'd0) && (bus.duty_r == 8'd0), 1'b1);
        check_bit({tag, "_busy"},  bus.busy, 1'b0);
    endtask

    // Monitor: one comparison per clock, just after the edge.
    always @(posedge clk_50) begin
        obs_t g, e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            g = '{bus.pwm_l, bus.pwm_r, bus.dir_l, bus.dir_r,
                  bus.duty_l, bus.duty_r, bus.busy};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL outputs @%0t: got pwm=%b%b dir=%b%b duty=%0d/%0d busy=%b, want pwm=%b%b dir=%b%b duty=%0d/%0d busy=%b",
                         $time, g.pwm_l, g.pwm_r, g.dir_l, g.dir_r, g.duty_l, g.duty_r, g.busy,
                         e.pwm_l, e.pwm_r, e.dir_l, e.dir_r, e.duty_l, e.duty_r, e.busy);
            end else begin
                $display("cycle @%0t: duty=%0d/%0d dir=%b%b busy=%b ok",
                         $time, g.duty_l, g.duty_r, g.dir_l, g.dir_r, g.busy);
            end
        end
    end

    initial begin
        int ds, len;
        bit es, reached;
        bus.drive_state = 4'd0;
        bus.estop       = 1'b0;
        model_reset();
        repeat (3) @(negedge clk_50);
        check_reset_values("reset");
        rst_n = 1'b1;

        // Soft start to FAST, then reverse through ramp-down and dead time.
        hold(5, 260);
        hold(6, 350);
        // Reversal aborted after three ticks.
        hold(5, 12);
        hold(6, 100);
        // Turn: left stops with dir unchanged, right to DUTY_TURN; then code 12.
        hold(1, 200);
        hold(12, 200);
        // MEDIUM, estop landing on a ramp-tick cycle, then release.
        hold(4, 200);
        while ((m_n % RAMP_DIV) != RAMP_DIV - 1) step(4, 1'b0);
        for (int i = 0; i < 5; i++) step(4, 1'b1);
        hold(4, 200);
        // Reversal right after estop release passes through dead time.
        hold(6, 3);
        hold(4, 60);

        // Reverse again and pull reset in the middle of the dead time.
        reached = 1'b0;
        for (int i = 0; i < 600 && !reached; i++) begin
            step(6, 1'b0);
            if (mch[0].dead_left > 0 && mch[0].dead_left < DEADTIME - 2) reached = 1'b1;
        end
        checks++;
        if (!reached) begin
            errors++;
            $display("FAIL dead_reach: got no dead time within 600 cycles, want dead time");
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        bus.drive_state = 4'd0;
        @(negedge clk_50);
        @(negedge clk_50);
        check_reset_values("reset_held");
        rst_n = 1'b1;
        model_reset();
        hold(0, 30);

        // Randomised drive codes (including unused ones) with occasional estop.
        for (int k = 0; k < 120; k++) begin
            ds  = $urandom_range(0, 15);
            len = $urandom_range(1, 40);
            es  = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < len; i++) step(ds, es && (i < 4));
        end
        hold(0, 300);

        @(negedge clk_50);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/motor_drive.md
# motor_drive

Converts the 4-bit drive-state code from the mode FSM into two PWM motor channels (left, right) with direction bits for the H-bridge. Applies a duty ramp (soft start/stop) and a mandatory ramp-down plus dead time before any direction reversal, so the FSM may change drive state on any cycle without stressing the motors. It sits directly downstream of the FSM, between it and the GPIO pins to the motor driver board.

## Interface
Parameters:
- PWM_PRESCALE, 98: clk_50 cycles per PWM counter increment (8-bit counter, ≈1.99 kHz PWM).
- RAMP_DIV, 50000: cycles between ramp ticks (1 ms).
- RAMP_STEP, 4: duty change per ramp tick.
- DEADTIME, 500000: cycles at zero duty before a direction flip (10 ms).
- DUTY_SLOW, 96; DUTY_MED, 160; DUTY_FAST, 240; DUTY_TURN, 128: 8-bit duty targets.

Ports:
- clk_50  in  1  system clock.
- rst_n  in  1  **one clock; reset is asynchronous and active-low.**
- drive_state  in  4  drive code from FSM.
- estop  in  1  immediate stop; level-sensitive.
- pwm_l, pwm_r  out  1  PWM enable per motor.
- dir_l, dir_r  out  1  1 = forward, 0 = reverse.
- duty_l, duty_r  out  8  current applied duty (status/HEX).
- busy  out  1  high while either channel is ramping or in dead time.

## Operation
- drive_state registered once (1 cycle). Codes map to (left, right) targets as (direction, duty):
  - STOP 0: (–, 0), (–, 0).
  - LEFT 1: (–, 0), (fwd, DUTY_TURN).
  - RIGHT 2: (fwd, DUTY_TURN), (–, 0).
  - SLOW 3 / MEDIUM 4 / FAST 5: both fwd at DUTY_SLOW / DUTY_MED / DUTY_FAST.
  - REVERSE 6: both rev at DUTY_SLOW.
  - LREVERSE 7: (–, 0), (rev, DUTY_TURN).
  - RREVERSE 8: (rev, DUTY_TURN), (–, 0).
  - 9–15: treated as STOP.
- Target duty 0 carries no direction; dir holds its current value.
- Per-channel FSM:
  - RUN: on each ramp tick, duty moves toward target by RAMP_STEP and saturates exactly at target (no overshoot, no wrap below 0 or above 255). If the target direction differs from dir and target duty > 0, go to RAMP_DOWN.
  - RAMP_DOWN: duty ramps toward 0. If the requested direction returns to dir, go back to RUN. When duty == 0, go to DEAD and load the dead counter with DEADTIME.
  - DEAD: the counter decrements every cycle with duty held at 0. At 0, dir takes the latest requested direction (unchanged if the target is then 0), then go to RUN. Always runs to completion.
- estop high: duty forced to 0 that cycle, state forced to RUN, dead counter cleared, duty held at 0 while estop is high. On release, normal ramping from 0. A subsequent reversal still passes through RAMP_DOWN (one cycle, since duty is already 0) and DEAD.
- PWM: an 8-bit counter advances once per PWM_PRESCALE cycles and wraps 255→0. pwm_x <= (pwm_cnt < duty_x). Duty 0 gives constant low; duty 255 gives high for 255 of 256 counts.
- busy = any channel not in RUN, or duty ≠ target on either channel.

## Timing
- Reset values: pwm_l = pwm_r = 0, dir_l = dir_r = 1, duty_l = duty_r = 0, busy = 0, all channels RUN, all counters 0.
- Reset is asynchronous on assertion; release takes effect on the first clk_50 edge.
- Target latency: 1 cycle from drive_state to target. The first duty change occurs on the next ramp tick, which is free-running (phase not reset by drive_state changes).
- duty_x updates on the ramp tick cycle. pwm_x reflects the new duty 1 cycle later, at the current counter position.
- Full ramp 0→DUTY_FAST: ceil(240/RAMP_STEP) = 60 ticks.
- Simultaneous estop and ramp tick: estop wins.
- Simultaneous DEAD expiry and a target change: the flip uses the target registered that cycle.
- rst_n asserted mid-ramp or mid-dead time: immediate return to the reset values.

## Structure
- Shared package drive_pkg holds:
  - the drive-state enum (STOP…RREVERSE, 4-bit), shared with the FSM;
  - the channel-state enum (RUN, RAMP_DOWN, DEAD);
  - the mapping function from drive code to (direction, duty) per side.
- Sub-module motor_channel: ramp, channel FSM, dead counter and PWM compare. Instantiated twice.
- The top level holds the input register, the PWM prescaler/counter, the ramp tick generator and the busy logic.

## Test plan
All scenarios use PWM_PRESCALE=1, RAMP_DIV=4, RAMP_STEP=4, DEADTIME=8.
- Reset, then drive_state=5 → duty_l and duty_r rise 0,4,8,…,240, one step every 4 cycles; settle after 60 ticks; busy drops the cycle duty reaches 240; dir both 1.
- FAST held, then drive_state=6 → both ramp down to 0, DEAD for 8 cycles with pwm = 0, dir → 0, ramp up to 96.
- From REVERSE steady (dir = 0, duty = 96), drive_state=5 for 3 ticks, then 6 again → RAMP_DOWN aborts back to RUN, dir stays 0, and duty ramps back to 96 with no DEAD state.
- drive_state=1 → duty_l ramps to 0 with dir_l unchanged; duty_r → 128, dir_r = 1. Then drive_state=12 → both ramp to 0.
- MEDIUM steady, estop high on a ramp-tick cycle → duty_l = duty_r = 0 on the next cycle and pwm low; on estop release, ramp from 0 to 160.
- rst_n low during DEAD → all outputs at reset values asynchronously. After release with drive_state=0, outputs stay idle.
